// File: rtl/shared_mem.sv
// ============================================================================
// Module   : shared_mem
// Purpose  : Two-port shared main memory behind the MSI caches; round-robin
//            arbitration, fixed access latency, registered completion pulses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef IOSTATEWIDTH
`define IOSTATEWIDTH 2
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 16
`endif
`ifndef WORDWIDTH
`define WORDWIDTH 16
`endif
`ifndef IDEL
`define IDEL 2'b00
`endif
`ifndef RD
`define RD 2'b01
`endif
`ifndef WT
`define WT 2'b10
`endif

module shared_mem #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [`IOSTATEWIDTH-1:0]  rwFromCache0,
  input  logic [`IOSTATEWIDTH-1:0]  rwFromCache1,
  input  logic [`ADDRWIDTH-1:0]     addrFromCache0,
  input  logic [`ADDRWIDTH-1:0]     addrFromCache1,
  input  logic [`WORDWIDTH-1:0]     dataFromCache0,
  input  logic [`WORDWIDTH-1:0]     dataFromCache1,
  output logic                      readEnToCache0,
  output logic                      readEnToCache1,
  output logic                      writeDoneToCache0,
  output logic                      writeDoneToCache1,
  output logic [`WORDWIDTH-1:0]     dataToCache0,
  output logic [`WORDWIDTH-1:0]     dataToCache1,
  output logic                      busy
);

  localparam int c_idxWidth = $clog2(DEPTH);
  localparam int c_cntWidth = $clog2(LATENCY) + 1;
  localparam logic [c_cntWidth-1:0] c_latLoad = c_cntWidth'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state, w_nextState;

  logic [`WORDWIDTH-1:0] r_mem [DEPTH];

  logic                  r_pend0, r_pend1;
  logic                  r_wr0, r_wr1;
  logic [c_idxWidth-1:0] r_idx0, r_idx1;
  logic [`WORDWIDTH-1:0] r_data0, r_data1;
  logic                  r_grant, r_lastGrant;
  logic [c_cntWidth-1:0] r_cnt;

  logic                  w_req0, w_req1, w_cap0, w_cap1, w_avail0, w_avail1;
  logic                  w_inWr0, w_inWr1;
  logic [c_idxWidth-1:0] w_inIdx0, w_inIdx1;
  logic [`WORDWIDTH-1:0] w_inData0, w_inData1;
  logic                  w_grant, w_grantPort, w_complete, w_release;
  logic                  w_accPort, w_accWr;
  logic [c_idxWidth-1:0] w_accIdx;
  logic [`WORDWIDTH-1:0] w_accData;
  logic                  w_unusedAddrBits;

  assign w_unusedAddrBits = ^{addrFromCache0[`ADDRWIDTH-1:c_idxWidth],
                              addrFromCache1[`ADDRWIDTH-1:c_idxWidth]};

  // Unknown rw codes fall out as IDEL; a slot stays occupied until its done pulse ends.
  assign w_req0   = (rwFromCache0 == `RD) || (rwFromCache0 == `WT);
  assign w_req1   = (rwFromCache1 == `RD) || (rwFromCache1 == `WT);
  assign w_cap0   = !r_pend0 && w_req0;
  assign w_cap1   = !r_pend1 && w_req1;
  assign w_avail0 = r_pend0 || w_cap0;
  assign w_avail1 = r_pend1 || w_cap1;

  assign w_inWr0   = w_cap0 ? (rwFromCache0 == `WT) : r_wr0;
  assign w_inWr1   = w_cap1 ? (rwFromCache1 == `WT) : r_wr1;
  assign w_inIdx0  = w_cap0 ? addrFromCache0[c_idxWidth-1:0] : r_idx0;
  assign w_inIdx1  = w_cap1 ? addrFromCache1[c_idxWidth-1:0] : r_idx1;
  assign w_inData0 = w_cap0 ? dataFromCache0 : r_data0;
  assign w_inData1 = w_cap1 ? dataFromCache1 : r_data1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_grantPort = r_grant;
    w_complete  = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_avail0 || w_avail1) begin
          w_grant     = 1'b1;
          w_grantPort = (w_avail0 && w_avail1) ? ~r_lastGrant : w_avail1;
          if (LATENCY == 1) begin
            w_complete  = 1'b1;
            w_nextState = S_DONE;
          end else begin
            w_nextState = S_SERVE;
          end
        end
      end
      S_SERVE: begin
        if (r_cnt == c_cntWidth'(1)) begin
          w_complete  = 1'b1;
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_release   = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
    w_accPort = w_grant ? w_grantPort : r_grant;
    w_accWr   = w_accPort ? w_inWr1   : w_inWr0;
    w_accIdx  = w_accPort ? w_inIdx1  : w_inIdx0;
    w_accData = w_accPort ? w_inData1 : w_inData0;
  end

  // A write is committed only on a completion edge that is not also a reset edge.
  always_ff @(posedge clk) begin
    if (!reset && w_complete && w_accWr) r_mem[w_accIdx] <= w_accData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend0           <= 1'b0;
      r_pend1           <= 1'b0;
      r_grant           <= 1'b0;
      r_lastGrant       <= 1'b1;
      r_cnt             <= '0;
      readEnToCache0    <= 1'b0;
      readEnToCache1    <= 1'b0;
      writeDoneToCache0 <= 1'b0;
      writeDoneToCache1 <= 1'b0;
      dataToCache0      <= '0;
      dataToCache1      <= '0;
      busy              <= 1'b0;
    end else begin
      if (w_cap0) begin
        r_pend0 <= 1'b1;
        r_wr0   <= w_inWr0;
        r_idx0  <= w_inIdx0;
        r_data0 <= w_inData0;
      end else if (w_release && !r_grant) begin
        r_pend0 <= 1'b0;
      end
      if (w_cap1) begin
        r_pend1 <= 1'b1;
        r_wr1   <= w_inWr1;
        r_idx1  <= w_inIdx1;
        r_data1 <= w_inData1;
      end else if (w_release && r_grant) begin
        r_pend1 <= 1'b0;
      end

      if (w_grant) begin
        r_grant     <= w_grantPort;
        r_lastGrant <= w_grantPort;
        r_cnt       <= c_latLoad;
      end else if (r_state == S_SERVE) begin
        r_cnt <= r_cnt - c_cntWidth'(1);
      end

      readEnToCache0    <= w_complete && !w_accWr && !w_accPort;
      readEnToCache1    <= w_complete && !w_accWr &&  w_accPort;
      writeDoneToCache0 <= w_complete &&  w_accWr && !w_accPort;
      writeDoneToCache1 <= w_complete &&  w_accWr &&  w_accPort;
      if (w_complete && !w_accWr && !w_accPort) dataToCache0 <= r_mem[w_accIdx];
      if (w_complete && !w_accWr &&  w_accPort) dataToCache1 <= r_mem[w_accIdx];
      busy <= (w_nextState != S_IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shared_mem.sv
// ============================================================================
// Module   : tb_shared_mem
// Purpose  : Directed self-checking bench for shared_mem (LATENCY 4 and 2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef IDEL
`define IDEL 2'b00
`endif
`ifndef RD
`define RD 2'b01
`endif
`ifndef WT
`define WT 2'b10
`endif

module tb_shared_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  rw0, rw1, rwB0, rwB1;
  logic [15:0] addr0, addr1, wdat0, wdat1, addrB0, addrB1, datB0, datB1;
  logic        re0, re1, wd0, wd1, busy;
  logic        reB0, reB1, wdB0, wdB1, busyB;
  logic [15:0] rd0, rd1, rdB0, rdB1;

  shared_mem #(.DEPTH(256), .LATENCY(4)) dut (
    .clk(clk), .reset(reset),
    .rwFromCache0(rw0), .rwFromCache1(rw1),
    .addrFromCache0(addr0), .addrFromCache1(addr1),
    .dataFromCache0(wdat0), .dataFromCache1(wdat1),
    .readEnToCache0(re0), .readEnToCache1(re1),
    .writeDoneToCache0(wd0), .writeDoneToCache1(wd1),
    .dataToCache0(rd0), .dataToCache1(rd1),
    .busy(busy)
  );

  shared_mem #(.DEPTH(256), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .rwFromCache0(rwB0), .rwFromCache1(rwB1),
    .addrFromCache0(addrB0), .addrFromCache1(addrB1),
    .dataFromCache0(datB0), .dataFromCache1(datB1),
    .readEnToCache0(reB0), .readEnToCache1(reB1),
    .writeDoneToCache0(wdB0), .writeDoneToCache1(wdB1),
    .dataToCache0(rdB0), .dataToCache1(rdB1),
    .busy(busyB)
  );

  int nChk  = 0;
  int nFail = 0;

  // pulse counts / first-pulse cycle for re0, re1, wd0, wd1 within a watch window
  int          pc [4];
  int          pa [4];
  logic [15:0] pd0, pd1;
  logic        b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void note(input int k, input logic v, input int i);
    if (v) begin
      pc[k]++;
      if (pa[k] < 0) pa[k] = i;
    end
  endfunction

  // Requests set up beforehand are sampled at the first edge (cycle 0), then dropped.
  task automatic watch(input int n);
    for (int j = 0; j < 4; j++) begin pc[j] = 0; pa[j] = -1; end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin rw0 = `IDEL; rw1 = `IDEL; b0 = busy; end
      note(0, re0, i); note(1, re1, i); note(2, wd0, i); note(3, wd1, i);
      if (re0) pd0 = rd0;
      if (re1) pd1 = rd1;
    end
  endtask

  initial begin
    int          mask;
    int          nDone;
    logic [15:0] lastB;
    reset = 1'b1;
    rw0 = `IDEL; rw1 = `IDEL; addr0 = '0; addr1 = '0; wdat0 = '0; wdat1 = '0;
    rwB0 = `IDEL; rwB1 = `IDEL; addrB0 = '0; addrB1 = '0; datB0 = '0; datB1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_outputs", {re0, re1, wd0, wd1, busy, rd0, rd1}, 64'd0);
    end
    check("idle_outputs_l2", {reB0, reB1, wdB0, wdB1, busyB, rdB0, rdB1}, 64'd0);

    // single-pulse write then read on port 0
    rw0 = `WT; addr0 = 16'h0005; wdat0 = 16'hA5A5;
    watch(6);
    check("wt0_busy_k", b0, 1);
    check("wt0_done_count", pc[2], 1);
    check("wt0_done_cycle", pa[2], 3);
    check("wt0_busy_after", busy, 0);
    rw0 = `RD; addr0 = 16'h0005;
    watch(6);
    check("rd0_count", pc[0], 1);
    check("rd0_cycle", pa[0], 3);
    check("rd0_data", pd0, 16'hA5A5);
    check("rd0_hold", rd0, 16'hA5A5);

    // port 1 write leaves lastGrant=1, so port 0 wins the next tie
    rw1 = `WT; addr1 = 16'h0020; wdat1 = 16'h2020;
    watch(6);
    check("wt1_done_cycle", pa[3], 3);
    rw0 = `RD; addr0 = 16'h0005; rw1 = `RD; addr1 = 16'h0020;
    watch(11);
    check("tie1_p0_cycle", pa[0], 3);
    check("tie1_p1_cycle", pa[1], 8);
    check("tie1_counts", {pc[0], pc[1]}, {32'd1, 32'd1});
    check("tie1_p0_data", pd0, 16'hA5A5);
    check("tie1_p1_data", pd1, 16'h2020);

    // port 0 alone leaves lastGrant=0, so port 1 wins the next tie
    rw0 = `RD; addr0 = 16'h0020;
    watch(6);
    check("solo_p0_data", pd0, 16'h2020);
    rw0 = `RD; addr0 = 16'h0020; rw1 = `RD; addr1 = 16'h0005;
    watch(11);
    check("tie2_p1_cycle", pa[1], 3);
    check("tie2_p0_cycle", pa[0], 8);
    check("tie2_p1_data", pd1, 16'hA5A5);

    // address wrap modulo DEPTH
    rw1 = `WT; addr1 = 16'h0105; wdat1 = 16'h1234;
    watch(6);
    check("wrap_wt_cycle", pa[3], 3);
    rw0 = `RD; addr0 = 16'h0005;
    watch(6);
    check("wrap_rd_data", pd0, 16'h1234);

    // reset aborts an in-flight write
    rw0 = `WT; addr0 = 16'h0007; wdat0 = 16'h0011;
    watch(6);
    check("pre_wt_cycle", pa[2], 3);
    rw0 = `WT; addr0 = 16'h0007; wdat0 = 16'hFFFF;
    @(posedge clk); #1 rw0 = `IDEL;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("reset_outputs", {re0, re1, wd0, wd1, busy, rd0, rd1}, 64'd0);
    reset = 1'b0;
    watch(5);
    check("abort_no_done", pc[2], 0);
    rw0 = `RD; addr0 = 16'h0007;
    watch(6);
    check("abort_rd_data", pd0, 16'h0011);

    // LATENCY=2 instance: done one edge after the sample edge
    rwB0 = `WT; addrB0 = 16'h0003; datB0 = 16'h0333;
    @(posedge clk); #1 rwB0 = `IDEL;
    check("l2_wt_k", wdB0, 0);
    @(posedge clk); #1;
    check("l2_wt_k1", wdB0, 1);
    @(posedge clk); #1;
    check("l2_wt_k2", wdB0, 0);
    @(posedge clk); #1;

    // level-held read: completions every LATENCY+1 cycles, none after dropping
    rwB0 = `RD; addrB0 = 16'h0003;
    mask = 0; nDone = 0; lastB = '0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (i == 11) rwB0 = `IDEL;
      if (reB0) begin
        mask = mask | (1 << i);
        nDone++;
        lastB = rdB0;
      end
    end
    check("l2_level_mask", mask, 32'h0000_0492);
    check("l2_level_count", nDone, 4);
    check("l2_level_data", lastB, 16'h0333);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule

`default_nettype wire
